// File: rtl/rfx_axil_pkg.sv
// rtl/rfx_axil_pkg.sv - response codes, FSM state types and address decode for rfx_axil_regbank
package rfx_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ADDR_W      = 6;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  // Byte address to 32-bit word slot; the two byte-lane bits are dropped.
  function automatic logic [3:0] word_idx(input logic [ADDR_W-1:0] addr);
    return 4'(addr >> 2);
  endfunction

endpackage

// File: rtl/rfx_axil_regbank_if.sv
// rtl/rfx_axil_regbank_if.sv - AXI4-Lite bus bundle with initiator and responder views
interface rfx_axil_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rfx_axil_bytereg.sv
// rtl/rfx_axil_bytereg.sv - 32-bit control register with byte enables and a registered write strobe
module rfx_axil_bytereg #(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_d,
  output logic [31:0] o_q,
  output logic        o_pulse
);

  logic [31:0] r_q;
  logic        r_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= RESET_VAL;
      r_pulse <= 1'b0;
    end else begin
      // An all-zero strobe is a no-op write and must not signal the fabric.
      r_pulse <= i_we & (|i_be);
      for (int k = 0; k < 4; k++) begin
        if (i_we && i_be[k]) r_q[8*k +: 8] <= i_d[8*k +: 8];
      end
    end
  end

  assign o_q     = r_q;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/rfx_axil_regbank.sv
// rtl/rfx_axil_regbank.sv - AXI4-Lite register bank; RFX_REGBANK_SLVERR_EN enables SLVERR on bad slots
module rfx_axil_regbank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          N_REGS             = 4,
  parameter logic [31:0] REG0_RESET         = 32'h0000_0000
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_areset,
  rfx_axil_regbank_if.slave         s00_axi,
  output logic [32*(N_REGS-1)-1:0]  ctrl_regs,
  input  logic [31:0]               status_in,
  output logic [N_REGS-2:0]         wr_pulse
);
  import rfx_axil_pkg::*;

  localparam int         N_RW   = N_REGS - 1;
  localparam logic [3:0] RO_IDX = 4'(N_REGS - 1);

  wstate_t r_wstate;
  rstate_t r_rstate;
  logic    r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   r_waddr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] r_wstrb;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_unused;
  logic [3:0]  w_cidx, w_cstrb, w_ridx;
  logic [31:0] w_cdata, w_rd_val;
  logic [1:0]  w_wresp, w_rresp;
  logic [31:0] w_regs [N_RW];

  assign w_aw_hs  = s00_axi.awvalid & r_awready;
  assign w_w_hs   = s00_axi.wvalid & r_wready;
  assign w_ar_hs  = s00_axi.arvalid & r_arready;
  assign w_ridx   = word_idx(s00_axi.araddr);
  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot};

  // The committed beat takes address and data from the wire or from whichever half was latched earlier.
  always_comb begin
    w_commit = 1'b0;
    w_cidx   = word_idx(s00_axi.awaddr);
    w_cdata  = s00_axi.wdata;
    w_cstrb  = s00_axi.wstrb;
    case (r_wstate)
      W_IDLE:    w_commit = w_aw_hs & w_w_hs;
      W_HAVE_AW: begin
        w_commit = w_w_hs;
        w_cidx   = word_idx(r_waddr);
      end
      W_HAVE_W:  begin
        w_commit = w_aw_hs;
        w_cdata  = r_wdata;
        w_cstrb  = r_wstrb;
      end
      default:   w_commit = 1'b0;
    endcase
  end

`ifdef RFX_REGBANK_SLVERR_EN
  assign w_wresp = (w_cidx >= RO_IDX) ? RESP_SLVERR : RESP_OKAY;
  assign w_rresp = (w_ridx > RO_IDX) ? RESP_SLVERR : RESP_OKAY;
`else
  assign w_wresp = RESP_OKAY;
  assign w_rresp = RESP_OKAY;
`endif

  for (genvar g = 0; g < N_RW; g++) begin : g_reg
    rfx_axil_bytereg #(
      .RESET_VAL (g == 0 ? REG0_RESET : 32'h0)
    ) u_reg (
      .clk     (s00_axi_aclk),
      .rst     (s00_axi_areset),
      .i_we    (w_commit && (w_cidx == 4'(g))),
      .i_be    (w_cstrb),
      .i_d     (w_cdata),
      .o_q     (w_regs[g]),
      .o_pulse (wr_pulse[g])
    );
    assign ctrl_regs[32*g +: 32] = w_regs[g];
  end

  always_comb begin
    w_rd_val = 32'h0;
    for (int i = 0; i < N_RW; i++) begin
      if (w_ridx == 4'(i)) w_rd_val = w_regs[i];
    end
    if (w_ridx == RO_IDX) w_rd_val = status_in;
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (w_commit) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wresp;
            r_wstate  <= W_RESP;
          end else if (w_aw_hs) begin
            r_waddr   <= s00_axi.awaddr;
            r_awready <= 1'b0;
            r_wstate  <= W_HAVE_AW;
          end else if (w_w_hs) begin
            r_wdata   <= s00_axi.wdata;
            r_wstrb   <= s00_axi.wstrb;
            r_wready  <= 1'b0;
            r_wstate  <= W_HAVE_W;
          end
        end
        W_HAVE_AW, W_HAVE_W: begin
          if (w_commit) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wresp;
            r_wstate  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s00_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rdata   <= w_rd_val;
            r_rresp   <= w_rresp;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s00_axi.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_wready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = r_bresp;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = r_rresp;

endmodule

// File: tb/tb_rfx_axil_regbank.sv
// tb/tb_rfx_axil_regbank.sv - scoreboard bench for rfx_axil_regbank with a behavioural register model
module tb_rfx_axil_regbank;

  localparam logic [31:0] R0_RST = 32'hA5A5_0F0F;
  localparam int          TMO    = 40;

  typedef struct { logic [1:0] resp; logic [2:0] pulse; int cyc; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; int cyc; } r_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] status_in = 32'h0;
  logic [95:0] ctrl_regs;
  logic [2:0]  wr_pulse;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] m_reg [3];
  b_exp_t      b_q [$];
  r_exp_t      r_q [$];

  rfx_axil_regbank_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  rfx_axil_regbank #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .N_REGS             (4),
    .REG0_RESET         (R0_RST)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi        (bus),
    .ctrl_regs      (ctrl_regs),
    .status_in      (status_in),
    .wr_pulse       (wr_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tmo_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual timeout required handshake within %0d cycles", name, TMO);
  endtask

  // Reference model: three RW words, one status word, everything above reads as zero.
  function automatic logic [31:0] exp_rdata(input int slot);
    if (slot < 3) return m_reg[slot];
    if (slot == 3) return status_in;
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_wresp(input int slot);
`ifdef RFX_REGBANK_SLVERR_EN
    return (slot >= 3) ? 2'b10 : 2'b00;
`else
    return (slot >= 0) ? 2'b00 : 2'b00;
`endif
  endfunction

  function automatic logic [1:0] exp_rresp(input int slot);
`ifdef RFX_REGBANK_SLVERR_EN
    return (slot >= 4) ? 2'b10 : 2'b00;
`else
    return (slot >= 0) ? 2'b00 : 2'b00;
`endif
  endfunction

  task automatic model_write(input int slot, input logic [31:0] data, input logic [3:0] strb);
    if (slot < 3)
      for (int k = 0; k < 4; k++)
        if (strb[k]) m_reg[slot][8*k +: 8] = data[8*k +: 8];
  endtask

  task automatic model_reset();
    m_reg[0] = R0_RST;
    m_reg[1] = 32'h0;
    m_reg[2] = 32'h0;
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 3; i++) chk($sformatf("ctrl_reg%0d", i), ctrl_regs[32*i +: 32], m_reg[i]);
  endtask

  task automatic wait_b(input int dly);
    int t = 0;
    @(negedge clk);
    while (!bus.bvalid && t < TMO) begin @(negedge clk); t++; end
    if (!bus.bvalid) begin tmo_fail("b_wait"); return; end
    repeat (dly) @(negedge clk);
    @(posedge clk); #1 bus.bready = 1'b1;
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask

  task automatic wait_r(input int dly);
    int t = 0;
    @(negedge clk);
    while (!bus.rvalid && t < TMO) begin @(negedge clk); t++; end
    if (!bus.rvalid) begin tmo_fail("r_wait"); return; end
    repeat (dly) @(negedge clk);
    @(posedge clk); #1 bus.rready = 1'b1;
    @(posedge clk); #1 bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int aw_c = 0, w_c = 0, slot;
    b_exp_t e;
    slot = int'(addr[5:2]);
    fork
      begin : aw_ch
        int t;
        t = 0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        bus.awaddr = addr; bus.awvalid = 1'b1;
        @(negedge clk);
        while (!bus.awready && t < TMO) begin @(negedge clk); t++; end
        if (!bus.awready) tmo_fail("aw_wait");
        @(posedge clk); #1 bus.awvalid = 1'b0;
        aw_c = cyc;
      end
      begin : w_ch
        int t;
        t = 0;
        repeat (w_dly) begin @(posedge clk); #1; end
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        @(negedge clk);
        while (!bus.wready && t < TMO) begin @(negedge clk); t++; end
        if (!bus.wready) tmo_fail("w_wait");
        @(posedge clk); #1 bus.wvalid = 1'b0;
        w_c = cyc;
      end
    join
    model_write(slot, data, strb);
    e.resp  = exp_wresp(slot);
    e.pulse = (slot < 3 && strb != 4'h0) ? 3'(1 << slot) : 3'b000;
    e.cyc   = (aw_c > w_c) ? aw_c : w_c;
    b_q.push_back(e);
    wait_b(b_dly);
    chk_regs();
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_dly);
    int t = 0, slot;
    r_exp_t e;
    slot = int'(addr[5:2]);
    bus.araddr = addr; bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && t < TMO) begin @(negedge clk); t++; end
    if (!bus.arready) tmo_fail("ar_wait");
    e.data = exp_rdata(slot); e.resp = exp_rresp(slot); e.cyc = cyc + 1;
    r_q.push_back(e);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    wait_r(r_dly);
  endtask

  // Write and read of the same address handshake on the same edge; the read must see the old value.
  task automatic rw_same(input logic [5:0] addr, input logic [31:0] data);
    int t = 0, slot;
    r_exp_t re;
    b_exp_t be;
    slot = int'(addr[5:2]);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = 4'hF; bus.araddr = addr;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(negedge clk);
    while (!(bus.awready && bus.wready && bus.arready) && t < TMO) begin @(negedge clk); t++; end
    if (!(bus.awready && bus.wready && bus.arready)) tmo_fail("rw_wait");
    re.data = exp_rdata(slot); re.resp = exp_rresp(slot); re.cyc = cyc + 1;
    r_q.push_back(re);
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    model_write(slot, data, 4'hF);
    be.resp = exp_wresp(slot);
    be.pulse = (slot < 3) ? 3'(1 << slot) : 3'b000;
    be.cyc = cyc;
    b_q.push_back(be);
    wait_b(0);
    wait_r(0);
    chk_regs();
  endtask

  initial begin : monitor
    bit pb = 1'b0, pr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 1'b0; pr = 1'b0;
      end else begin
        if (bus.bvalid) begin
          chk("awready_in_resp", 32'(bus.awready), 32'h0);
          chk("wready_in_resp", 32'(bus.wready), 32'h0);
          if (b_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL b_unexpected: actual bvalid=1 required no response");
          end else begin
            chk("bresp", 32'(bus.bresp), 32'(b_q[0].resp));
            if (!pb) begin
              chk("b_latency", 32'(cyc), 32'(b_q[0].cyc));
              chk("wr_pulse", 32'(wr_pulse), 32'(b_q[0].pulse));
            end else chk("wr_pulse_idle", 32'(wr_pulse), 32'h0);
            if (bus.bready) b_q.delete(0);
          end
        end else chk("wr_pulse_idle", 32'(wr_pulse), 32'h0);
        if (bus.rvalid) begin
          chk("arready_in_resp", 32'(bus.arready), 32'h0);
          if (r_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL r_unexpected: actual rvalid=1 required no response");
          end else begin
            chk("rdata", bus.rdata, r_q[0].data);
            chk("rresp", 32'(bus.rresp), 32'(r_q[0].resp));
            if (!pr) chk("r_latency", 32'(cyc), 32'(r_q[0].cyc));
            if (bus.rready) r_q.delete(0);
          end
        end
        pb = bus.bvalid;
        pr = bus.rvalid;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [5:0] a;
    int t;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 32'h0);
    chk("rst_wready", 32'(bus.wready), 32'h0);
    chk("rst_arready", 32'(bus.arready), 32'h0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_bresp", 32'(bus.bresp), 32'h0);
    chk("rst_rresp", 32'(bus.rresp), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'h0);
    chk_regs();
    @(posedge clk); #1 rst = 1'b0;

    axi_write(6'h00, 32'h0101_FFFF, 4'hF, 0, 0, 0);
    axi_read(6'h00, 0);
    axi_write(6'h04, 32'hABCD_0001, 4'hF, 3, 0, 1);
    axi_read(6'h04, 2);
    axi_write(6'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(6'h08, 32'hDEAD_0011, 4'b0101, 0, 2, 0);
    axi_read(6'h08, 0);
    axi_write(6'h01, 32'h1234_5678, 4'h0, 0, 0, 0);
    status_in = 32'hBEEF_0011;
    axi_read(6'h0C, 0);
    axi_write(6'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_read(6'h0E, 1);
    axi_read(6'h30, 0);
    axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
    axi_write(6'h04, 32'h5555_AAAA, 4'hF, 0, 0, 5);
    rw_same(6'h04, 32'h0F0F_0F0F);
    axi_read(6'h04, 0);

    repeat (80) begin
      if ($urandom_range(0, 3) == 0) a = 6'($urandom_range(0, 63));
      else a = {2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) status_in = $urandom;
      case ($urandom_range(0, 4))
        0, 1: axi_read(a, $urandom_range(0, 3));
        2, 3: axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3));
        default: rw_same(a, $urandom);
      endcase
    end

    axi_write(6'h00, 32'h0000_1234, 4'hF, 0, 0, 0);
    bus.awaddr = 6'h00; bus.awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.awready && t < TMO) begin @(negedge clk); t++; end
    if (!bus.awready) tmo_fail("aw_wait_rst");
    @(posedge clk); #1 bus.awvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_awready", 32'(bus.awready), 32'h0);
    chk("midrst_wready", 32'(bus.wready), 32'h0);
    chk("midrst_arready", 32'(bus.arready), 32'h0);
    chk("midrst_bvalid", 32'(bus.bvalid), 32'h0);
    chk("midrst_rvalid", 32'(bus.rvalid), 32'h0);
    chk_regs();
    b_q.delete();
    r_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    axi_read(6'h00, 0);
    axi_write(6'h00, 32'hCAFE_0000, 4'b1100, 0, 0, 0);
    axi_read(6'h00, 0);

    repeat (3) @(posedge clk);
    chk("b_queue_empty", 32'(b_q.size()), 32'h0);
    chk("r_queue_empty", 32'(r_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rfx_axil_regbank.md
Name: rfx_axil_regbank

Overview:
- AXI4-Lite responder (slave) exposing a bank of 32-bit control/status registers to a PS-side AXI4-Lite initiator.
- Sits between the interconnect and the rfx logic cores (prescaler, timers).
- Drives RW control registers out to fabric and samples one status word in.
- Handles independent AW/W arrival, byte strobes, one outstanding write and one outstanding read.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; decodes 16 word slots.
- N_REGS, 4, implemented registers; slots 0..N_REGS-2 are RW, slot N_REGS-1 is RO status.
- REG0_RESET, 32'h0000_0000, reset value of register 0; registers 1..N_REGS-2 reset to 0.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_areset  in  1  asynchronous, active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid  in  1 / s00_axi_awready  out  1.
- s00_axi_wdata  in  32 / s00_axi_wstrb  in  4 / s00_axi_wvalid  in  1 / s00_axi_wready  out  1.
- s00_axi_bresp  out  2 / s00_axi_bvalid  out  1 / s00_axi_bready  in  1.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH / s00_axi_arprot  in  3 (ignored) / s00_axi_arvalid  in  1 / s00_axi_arready  out  1.
- s00_axi_rdata  out  32 / s00_axi_rresp  out  2 / s00_axi_rvalid  out  1 / s00_axi_rready  in  1.
- ctrl_regs  out  32*(N_REGS-1)  flat concatenation of RW registers; reg0 in bits [31:0].
- status_in  in  32  value returned for RO slot N_REGS-1.
- wr_pulse  out  N_REGS-1  one-cycle strobe when the matching RW register is written.

Behaviour:
Reset (async assert, sync deassert handled upstream):
- awready, wready, arready, bvalid and rvalid are 0.
- bresp, rresp and rdata are 0.
- ctrl regs take their reset values; wr_pulse is 0.

Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
- W_IDLE: awready = wready = 1.
  - AW and W in the same cycle: commit the write, go to W_RESP.
  - AW only: latch the address, go to W_HAVE_AW (awready = 0).
  - W only: latch data and strobe, go to W_HAVE_W.
- W_HAVE_AW: wait for W. W_HAVE_W: wait for AW. On the handshake, commit the write and go to W_RESP.
- Commit happens in the handshake cycle; the register updates on the next edge:
  - word index = addr[5:2]; addr[1:0] is ignored.
  - Per-byte update: byte k is written iff wstrb[k]. wstrb = 0 updates nothing but still responds.
  - wr_pulse[i] is high exactly one cycle after the commit, if slot i is RW and any strobe bit is set.
  - Writes to the RO slot or to slots >= N_REGS are discarded.
- W_RESP: bvalid = 1 and held stable until bready, then return to W_IDLE. No new AW or W is accepted while in W_RESP.
- Minimum write latency: one cycle from handshake to bvalid.

Read FSM states: R_IDLE, R_RESP.
- R_IDLE: arready = 1. On arvalid, rdata is registered from the decoded slot and the FSM goes to R_RESP; latency is 1 cycle.
  - RO slot returns status_in sampled in the AR handshake cycle.
  - Out-of-range slots return 0.
- R_RESP: rvalid = 1, with rdata and rresp held until rready.

Read/write interaction:
- The read and write FSMs are fully independent.
- A read and a write to the same register in the same cycle: the read returns the old value.

Responses:
- bresp and rresp are OKAY (2'b00) unless the optional feature is enabled.

Optional Feature:
- Macro RFX_REGBANK_SLVERR_EN.
- Defined: accesses to slots >= N_REGS, and writes to the RO slot, respond SLVERR (2'b10). Out-of-range reads also return rdata = 0.
- Undefined: every access responds OKAY; out-of-range and RO-slot writes are silently dropped.

Decomposition:
- Package rfx_axil_pkg holds:
  - response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - write-state and read-state enum typedefs;
  - an address-to-word-index function.
- One natural sub-module, rfx_axil_bytereg: a 32-bit register with async reset, 4-bit byte enable and write pulse, instantiated N_REGS-1 times.

Test Plan:
- Release reset, AW+W together at 0x0 with 32'h0101FFFF and wstrb F -> bvalid 1 cycle after the handshake, bresp 00, wr_pulse[0] high for 1 cycle. Read 0x0 -> rdata 32'h0101FFFF, rresp 00.
- W with 32'hABCD0001 at cycle n, AW 0x4 at n+3 -> write accepted only at n+3. Read 0x4 -> 32'hABCD0001.
- Preload 0x8 with 32'hFFFFFFFF, write 32'hDEAD0011 with wstrb 4'b0101 -> readback 32'hFFAD FF11 (bytes 0 and 2 updated).
- status_in = 32'hBEEF0011, read 0xC -> 32'hBEEF0011. Write 0xC -> register unchanged; bresp 00 without the macro, 10 with RFX_REGBANK_SLVERR_EN.
- Hold bready = 0 for 5 cycles after a write -> bvalid and bresp stable, awready low; the next AW is accepted only after the B handshake.
- Assert reset mid-write (in W_HAVE_AW) -> all valids/readies drop immediately, and a subsequent read of 0x0 returns REG0_RESET.
